rom_rr_arbiter: RTL
===================

Name: rom_rr_arbiter

Overview:
- Shares one single-port synchronous-read ROM (8 x 8-bit, 3-bit address, enable-gated output) among NUM_REQ requesters.
- Uses a work-conserving round-robin arbiter with a valid/grant handshake.
- Pipelines accesses at one accepted read per clock.
- Returns each read word tagged with the requester ID.
- Sits between the ROM and its client blocks; it is the only master driving the ROM address and enable.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 3, ROM address width.
- DATA_W, 8, ROM data width.
- ID_W, 2, requester ID width; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_req  input  NUM_REQ  per-requester read request; held until granted.
- i_addr  input  NUM_REQ*ADDR_W  packed addresses; requester k uses bits [k*ADDR_W +: ADDR_W].
- o_gnt  output  NUM_REQ  one-hot combinational grant. Transfer happens on the edge where i_req[k] && o_gnt[k].
- o_rom_en  output  1  ROM enable.
- o_rom_addr  output  ADDR_W  ROM address.
- i_rom_dout  input  DATA_W  ROM read data.
- o_rvalid  output  1  one-cycle pulse; o_rdata/o_rid valid.
- o_rdata  output  DATA_W  returned ROM word.
- o_rid  output  ID_W  index of the requester that owns o_rdata.
- o_busy  output  1  high while any read is in flight (stage 1 or stage 2 valid).

Behaviour:
Reset (async, i_rst=1):
- ptr=0, s1_vld=0, s2_vld=0, o_rvalid=0, o_rdata=0, o_rid=0.
- o_gnt=0 is forced regardless of i_req; o_rom_en=0; o_rom_addr=0.
- In-flight reads are discarded with no o_rvalid, including after deassertion.

Arbitration (combinational):
- Winner is the first k with i_req[k]=1, searching from ptr upward, modulo NUM_REQ.
- o_gnt = one-hot(winner) if any i_req, else 0.
- o_rom_addr = i_addr slice of the winner when a grant is active, else held at the last issued address.
- Accept edge = any (i_req & o_gnt). On it, ptr <= (winner+1) mod NUM_REQ. ptr is unchanged if there is no request.

Pipeline:
- Stage 1 (edge E, accept): the ROM samples o_rom_addr. Set s1_vld=1, s1_id=winner.
- Stage 2 (edge E+1): o_rdata <= i_rom_dout, o_rid <= s1_id, o_rvalid <= s1_vld.
- Latency: o_rvalid is high in the cycle following edge E+1, i.e. 2 clocks after accept.
- o_rom_en = (|o_gnt) | s1_vld. The enable is high in the sampling cycle and in the capture cycle, so i_rom_dout is never X when captured.
- Back-to-back accepts every cycle are allowed. Each gets its own o_rvalid pulse, in accept order.
- No backpressure on the return path: consumers must take o_rdata in its o_rvalid cycle.

Boundary conditions:
- Single requester holding i_req continuously is granted every cycle, giving one read per clock.
- All requesters active: grants rotate 0,1,2,3,0,... Each requester waits at most NUM_REQ-1 cycles.
- A requester dropping i_req before its grant is not served and does not move ptr.
- Address 7 and address 0 are both valid; there is no address checking.
- Bits of i_req at index >= NUM_REQ do not exist, and o_rid never exceeds NUM_REQ-1.
- Reset asserted mid-pipeline clears s1/s2 in the same instant. o_rvalid must not pulse for those reads.

Test Plan:
- Reset then idle: i_rst=1 for 2 cycles, i_req=0 -> o_gnt=0, o_rom_en=0, o_rvalid=0, o_busy=0.
- Single read: i_req=4'b0010, addr[1]=5 for one accept -> o_gnt=4'b0010 in that cycle; 2 cycles later o_rvalid=1, o_rdata=8'h05, o_rid=1; o_busy high for 2 cycles.
- Full round-robin: i_req=4'b1111 held 8 cycles, addr[k]=k+4 -> grant order 0,1,2,3,0,1,2,3; o_rdata sequence 04,05,06,07,04,... with matching o_rid; o_rvalid high 8 consecutive cycles.
- Pointer fairness: requester 2 granted, then i_req=4'b0101 -> next grant goes to 0 (wrap from ptr=3), then 2.
- Back-to-back single master: i_req[3]=1, addr stepping 0..7 each cycle -> o_rdata 00..07 on consecutive cycles, 2-cycle latency, o_rom_en continuously high.
- Reset mid-flight: accept at edge E, assert i_rst between E and E+1 -> o_rvalid stays 0 through E+3; ptr=0 after release.

Source files
------------

// File: rtl/rom_rr_arbiter.sv
// rom_rr_arbiter
//   Shares one synchronous-read ROM among NUM_REQ requesters. A work-conserving
//   round-robin arbiter picks one request per clock. Each accepted read returns
//   two clocks later on o_rdata, tagged with the requester index on o_rid.
//
// Ports
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_req, i_addr      per-requester request and packed addresses
//   o_gnt              one-hot combinational grant (transfer when i_req & o_gnt)
//   o_rom_en/o_rom_addr/i_rom_dout  ROM interface (this block is the only master)
//   o_rvalid/o_rdata/o_rid          return path, single-cycle pulse, no backpressure
//   o_busy             a read is in stage 1 or stage 2
module rom_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 8,
   parameter int ID_W    = 2
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
   output logic [NUM_REQ-1:0]        o_gnt,
   output logic                      o_rom_en,
   output logic [ADDR_W-1:0]         o_rom_addr,
   input  logic [DATA_W-1:0]         i_rom_dout,
   output logic                      o_rvalid,
   output logic [DATA_W-1:0]         o_rdata,
   output logic [ID_W-1:0]           o_rid,
   output logic                      o_busy
);

   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W-1:0] addr_q;
   logic              s1_vld_q;
   logic [ID_W-1:0]   s1_id_q;
   logic              rvalid_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ID_W-1:0]   rid_q;

   logic              win_found;
   logic [ID_W-1:0]   win_idx;
   logic [ADDR_W-1:0] win_addr;
   logic              accept;

   // Two-pass search: first the requesters at or above ptr, then wrap to the
   // lowest index. Equivalent to a modulo scan starting at ptr.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_addr  = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (!win_found && (j >= 32'(ptr_q)) && i_req[j]) begin
            win_found = 1'b1;
            win_idx   = ID_W'(j);
            win_addr  = i_addr[j*ADDR_W +: ADDR_W];
         end
      end
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         if (!win_found && i_req[j]) begin
            win_found = 1'b1;
            win_idx   = ID_W'(j);
            win_addr  = i_addr[j*ADDR_W +: ADDR_W];
         end
      end
   end

   // Grant is suppressed while reset is asserted, whatever i_req says.
   assign accept = win_found && !i_rst;

   always_comb begin
      o_gnt = '0;
      if (accept) begin
         o_gnt = NUM_REQ'(1) << win_idx;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         ptr_d = (32'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
      end
   end

   // Address is held at the last issued value when idle.
   assign o_rom_addr = accept ? win_addr : addr_q;
   assign o_rom_en   = accept | s1_vld_q;
   assign o_busy     = s1_vld_q | rvalid_q;
   assign o_rvalid   = rvalid_q;
   assign o_rdata    = rdata_q;
   assign o_rid      = rid_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ptr_q    <= '0;
         addr_q   <= '0;
         s1_vld_q <= 1'b0;
         s1_id_q  <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rid_q    <= '0;
      end else begin
         ptr_q    <= ptr_d;
         addr_q   <= o_rom_addr;
         s1_vld_q <= accept;
         if (accept) begin
            s1_id_q <= win_idx;
         end
         rvalid_q <= s1_vld_q;
         // Capture only when stage 1 held a read, so the ROM output was enabled.
         if (s1_vld_q) begin
            rdata_q <= i_rom_dout;
            rid_q   <= s1_id_q;
         end
      end
   end

endmodule
